computer_player_gen: RTL

- Parametrised automatic-opponent input generator for the game datapath.
- Each of CHANNELS independent channels runs an LFSR every enabled cycle and compares the LFSR value against a shared difficulty threshold under a selectable compare mode.
- A channel emits a one-cycle press pulse when the compare holds, rate-limited by a per-channel hold-off counter.
- Replaces the single fixed 10-bit greater-than comparator path. Outputs feed the same player-input logic as human key pulses.

---
 rtl/computer_player_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/computer_player_gen.sv
// computer_player_gen: per-channel LFSR opponents that compare against a difficulty threshold and emit rate-limited press pulses.
// Optional press counters are compiled in with `define COMP_PRESS_COUNT_EN.
`default_nettype none

module computer_player_gen #(
   parameter int WIDTH    = 10,
   parameter int CHANNELS = 1,
   parameter int SEED     = 1,
   parameter int HOLDOFF  = 0,
   parameter int CNT_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [1:0]                  mode,
   input  logic [WIDTH-1:0]            difficulty,
   output logic [CHANNELS-1:0]         press,
   output logic [WIDTH*CHANNELS-1:0]   rnd_dbg
`ifdef COMP_PRESS_COUNT_EN
   ,
   output logic [CNT_W*CHANNELS-1:0]   press_count
`endif
);

   localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);

   // Maximal-length Fibonacci tap masks; bit (t-1) set for each tap t.
   function automatic logic [15:0] tap_mask16(input int w);
      logic [15:0] m;
      case (w)
         4:       m = 16'h000C;
         5:       m = 16'h0014;
         6:       m = 16'h0030;
         7:       m = 16'h0060;
         8:       m = 16'h00B8;
         9:       m = 16'h0110;
         10:      m = 16'h0240;
         11:      m = 16'h0500;
         12:      m = 16'h0829;
         13:      m = 16'h100D;
         14:      m = 16'h2015;
         15:      m = 16'h6000;
         16:      m = 16'hD008;
         default: m = 16'h0240;
      endcase
      return m;
   endfunction

   function automatic logic [WIDTH-1:0] seed_of(input int c);
      logic [WIDTH-1:0] s;
      s = WIDTH'(SEED + c);
      return (s == '0) ? WIDTH'(1) : s;
   endfunction

   localparam logic [15:0]      TAPS16 = tap_mask16(WIDTH);
   localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam logic [WIDTH-1:0] SEED_C = seed_of(c);

      logic [WIDTH-1:0] lfsr_q, lfsr_d;
      logic [HO_W-1:0]  hold_q, hold_d;
      logic             press_q, press_d;
      logic             hit;

      always_comb begin
         case (mode)
            2'b00:   hit = difficulty >  lfsr_q;
            2'b01:   hit = difficulty >= lfsr_q;
            2'b10:   hit = difficulty <  lfsr_q;
            default: hit = 1'b0;
         endcase

         lfsr_d  = lfsr_q;
         hold_d  = hold_q;
         press_d = 1'b0;
         if (enable) begin
            lfsr_d  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
            press_d = hit && (hold_q == '0);
            if (press_d) begin
               hold_d = HO_LOAD;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HO_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lfsr_q  <= SEED_C;
            hold_q  <= '0;
            press_q <= 1'b0;
         end else begin
            lfsr_q  <= lfsr_d;
            hold_q  <= hold_d;
            press_q <= press_d;
         end
      end

      assign press[c]                   = press_q;
      assign rnd_dbg[c*WIDTH +: WIDTH]  = lfsr_q;

`ifdef COMP_PRESS_COUNT_EN
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturating: stops at all-ones rather than wrapping.
      always_comb begin
         cnt_d = cnt_q;
         if (press_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign press_count[c*CNT_W +: CNT_W] = cnt_q;
`endif
   end

`ifndef COMP_PRESS_COUNT_EN
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire
